// File: rtl/fetch_stage.sv
// Instruction fetch stage: launches imem requests, tracks in-flight responses and
// buffers fetched {pc, inst} pairs in a 2-entry queue presented to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_pc,
   input  logic        stall_f2,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] f2_pc,
   output logic [31:0] f2_inst,
   output logic        f2_is_a_inst
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;

   typedef enum logic {FETCH, REDIR_WAIT} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   tgt_q, tgt_d;
   logic              pend_q, pend_d;
   logic [1:0]        fcnt_q, fcnt_d;
   logic [XLEN-1:0]   fpc_q [DEPTH];
   logic [XLEN-1:0]   fpc_d [DEPTH];
   logic [XLEN-1:0]   finst_q [DEPTH];
   logic [XLEN-1:0]   finst_d [DEPTH];
   logic [1:0]        icnt_q, icnt_d;
   logic [XLEN-1:0]   ipc_q [DEPTH];
   logic [XLEN-1:0]   ipc_d [DEPTH];
   logic              idrop_q [DEPTH];
   logic              idrop_d [DEPTH];

   logic              pop, room, launch, accept, rsp, push;
   logic [2:0]        occ;

   // Request control: a pending (ungranted) request is held regardless of stalls.
   always_comb begin
      pop      = f2_is_a_inst & ~stall_f2;
      occ      = 3'(fcnt_q) + 3'(icnt_q) - 3'(pop);
      room     = occ < 3'd2;
      launch   = (state_q == FETCH) & ~redirect_valid & ~stall_pc & room;
      imem_req = ~rst & ((state_q == REDIR_WAIT) | pend_q | launch);
      accept   = imem_req & imem_gnt;
      rsp      = imem_rvalid & (icnt_q != 2'd0);
      push     = rsp & ~idrop_q[0] & ~redirect_valid;
   end

   assign imem_addr    = pc_q;
   assign f2_pc        = fpc_q[0];
   assign f2_inst      = finst_q[0];
   assign f2_is_a_inst = fcnt_q != 2'd0;

   // Next-state: in-flight queue, output queue, pc and redirect FSM.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      pend_d  = imem_req & ~imem_gnt;
      icnt_d  = icnt_q;
      ipc_d   = ipc_q;
      idrop_d = idrop_q;
      fcnt_d  = fcnt_q;
      fpc_d   = fpc_q;
      finst_d = finst_q;

      if (rsp) begin
         ipc_d[0]   = ipc_q[1];
         idrop_d[0] = idrop_q[1];
         icnt_d     = icnt_q - 2'd1;
      end
      if (redirect_valid) begin
         for (int i = 0; i < DEPTH; i++) idrop_d[i] = 1'b1;
      end
      if (accept) begin
         ipc_d[icnt_d[0]]   = pc_q;
         idrop_d[icnt_d[0]] = redirect_valid | (state_q == REDIR_WAIT);
         icnt_d             = icnt_d + 2'd1;
      end

      if (pop) begin
         fpc_d[0]   = fpc_q[1];
         finst_d[0] = finst_q[1];
         fcnt_d     = fcnt_q - 2'd1;
      end
      if (push) begin
         fpc_d[fcnt_d[0]]   = ipc_q[0];
         finst_d[fcnt_d[0]] = imem_rdata;
         fcnt_d             = fcnt_d + 2'd1;
      end
      if (redirect_valid) fcnt_d = 2'd0;

      case (state_q)
         FETCH: begin
            if (redirect_valid) begin
               if (imem_req & ~imem_gnt) begin
                  tgt_d   = redirect_pc;
                  state_d = REDIR_WAIT;
               end else begin
                  pc_d = redirect_pc;
               end
            end else if (accept) begin
               pc_d = pc_q + 32'd4;
            end
         end
         REDIR_WAIT: begin
            if (redirect_valid) tgt_d = redirect_pc;
            if (imem_gnt) begin
               pc_d    = redirect_valid ? redirect_pc : tgt_q;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= '0;
         pend_q  <= 1'b0;
         fcnt_q  <= '0;
         icnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fpc_q[i]   <= '0;
            finst_q[i] <= '0;
            ipc_q[i]   <= '0;
            idrop_q[i] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
         fcnt_q  <= fcnt_d;
         icnt_q  <= icnt_d;
         fpc_q   <= fpc_d;
         finst_q <= finst_d;
         ipc_q   <= ipc_d;
         idrop_q <= idrop_d;
      end
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall_pc  input  1  hazard stall: no new imem request may be launched.
REQ-005 stall_f2  input  1  hazard stall: decode does not consume the F2 output this cycle.
REQ-006 redirect_valid  input  1  branch/trap redirect request, single-cycle pulse.
REQ-007 redirect_pc  input  32  redirect target, word aligned.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  request address, equal to pc register.
REQ-010 imem_gnt  input  1  request accepted this cycle (imem_req & imem_gnt).
REQ-011 imem_rvalid  input  1  response valid, exactly one cycle after each accepted request.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 f2_pc  output  32  PC of the instruction presented to decode.
REQ-014 f2_inst  output  32  instruction presented to decode.
REQ-015 f2_is_a_inst  output  1  f2_pc/f2_inst hold a valid instruction.

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {pc, inst}; f2_* SHALL show the head entry and f2_is_a_inst SHALL equal FIFO non-empty.
REQ-017 The head entry SHALL be popped at a clock edge when f2_is_a_inst=1 and stall_f2=0; with stall_f2=1 f2_* SHALL be held unchanged.
REQ-018 An in-flight counter (0..2) SHALL count accepted requests whose response has not yet arrived.
REQ-019 In state FETCH, imem_req SHALL be 1 when stall_pc=0 and (FIFO count + in-flight − pops this cycle) < 2, else 0, unless a request is pending (REQ-020).
REQ-020 Once imem_req=1 without imem_gnt, imem_req and imem_addr SHALL stay asserted and stable until imem_gnt=1, regardless of stall_pc.
REQ-021 On an accepted request, pc SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and in-flight SHALL increment.
REQ-022 On imem_rvalid=1 the response SHALL be pushed with its request PC unless its drop flag is set, in which case it is discarded; in-flight SHALL decrement.
REQ-023 Push and pop in the same cycle SHALL both take effect; FIFO overflow SHALL be impossible by REQ-019.
REQ-024 Redirect in FETCH with no ungranted pending request: FIFO SHALL be flushed, all in-flight responses marked drop, pc <= redirect_pc; f2_is_a_inst SHALL be 0 the next cycle.
REQ-025 Redirect with an ungranted pending request: FIFO flushed, redirect_pc latched, state SHALL go to REDIR_WAIT; the pending request completes unchanged and its response is dropped.
REQ-026 In REDIR_WAIT, on imem_gnt: pc <= latched target, state -> FETCH; no new request is launched in that cycle.
REQ-027 A redirect arriving in REDIR_WAIT SHALL overwrite the latched target.
REQ-028 redirect_valid SHALL take priority over stall_pc and stall_f2; a response arriving in the redirect cycle SHALL be dropped.
REQ-029 Stage latency: request accepted at cycle N -> instruction at f2 from cycle N+2 when FIFO empty.

Reset
REQ-030 While rst=1: pc=RESET_PC, state=FETCH, FIFO empty, in-flight=0, drop flags clear, imem_req=0, f2_is_a_inst=0, f2_pc=0, f2_inst=0.
REQ-031 The first request (imem_addr=RESET_PC) SHALL be issued in the first cycle after rst deasserts; reset mid-operation SHALL discard all in-flight responses.

Verification
REQ-032 Reset release, gnt=1 always, no stalls -> imem_addr 0,4,8…; f2_pc=0 two cycles after first request, then one instruction per cycle.
REQ-033 stall_f2=1 for 3 cycles with gnt=1 -> FIFO fills to 2, imem_req drops to 0, f2_pc frozen, no instruction lost or duplicated after release.
REQ-034 stall_pc=1 while req granted each cycle -> imem_req=0 next cycle, pc frozen; release resumes at next sequential address.
REQ-035 redirect_pc=32'h0000_1000 with 2 in flight -> both responses dropped, next imem_addr=0x1000, f2_is_a_inst=0 until 0x1000 arrives.
REQ-036 redirect while imem_req=1, gnt=0 for 2 cycles -> imem_addr stable, REDIR_WAIT entered, old response dropped, then imem_addr=target.
REQ-037 pc=32'hFFFF_FFFC granted -> next imem_addr=32'h0000_0000.
